mem_port_arbiter: RTL and testbench

//  Shares one word-wide instruction/data memory port between instruction fetch (IF) and load/store (MEM).

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter_timeout_cnt.sv | 28 ++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the instruction/data memory port arbiter.
// State encodings and fixed memory-side values live here so every file agrees on them.
package mem_port_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE     = 2'd0;
   localparam logic [1:0] ARB_BUSY_IF  = 2'd1;
   localparam logic [1:0] ARB_BUSY_MEM = 2'd2;
   localparam logic [1:0] ARB_DONE     = 2'd3;

   localparam logic [3:0] SEL_ALL       = 4'hF;
   localparam logic       CHIP_ENABLE   = 1'b1;
   localparam logic       CHIP_DISABLE  = 1'b0;
   localparam logic       WRITE_ENABLE  = 1'b1;
   localparam logic       WRITE_DISABLE = 1'b0;
   localparam logic       RST_ENABLE    = 1'b1;

   function automatic logic is_busy(input logic [1:0] st);
      return (st == ARB_BUSY_IF) || (st == ARB_BUSY_MEM);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the port arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;
   logic              if_err;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_sel;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_err;

   logic              ram_ce;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [3:0]        ram_sel;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              ram_ack;

   logic              stallreq_if;
   logic              stallreq_mem;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata, ram_rdata, ram_ack,
      output if_ack, if_rdata, if_err, mem_ack, mem_rdata, mem_err,
      output ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, stallreq_if, stallreq_mem
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata, ram_rdata, ram_ack,
      input  if_ack, if_rdata, if_err, mem_ack, mem_rdata, mem_err,
      input  ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, stallreq_if, stallreq_mem
   );

endinterface

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Wait-cycle counter for one memory access: cleared outside an access, counts while enabled,
// and flags expiry on the last allowed cycle so the arbiter can abort in that same cycle.
module arb_timeout_cnt
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE || clear) begin
         count <= '0;
      end else if (enable && !expire) begin
         count <= count + CW'(1);
      end
   end

   assign expire = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: MEM has priority,
// IF is forced through after STARVE_MAX back-to-back MEM wins, hung accesses time out.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 15,
   parameter int STARVE_MAX = 4
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [1:0]        state;
   logic [SW-1:0]     starve_cnt;
   logic              grant_mem;
   logic              grant_if;
   logic              busy;
   logic              expire;
   logic              finish;
   logic [DATA_W-1:0] done_data;

   logic              ram_ce_q;
   logic              ram_we_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [3:0]        ram_sel_q;
   logic [DATA_W-1:0] ram_wdata_q;
   logic              if_ack_q;
   logic              if_err_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic              mem_ack_q;
   logic              mem_err_q;
   logic [DATA_W-1:0] mem_rdata_q;

   assign busy = is_busy(state);

   // MEM wins a tie unless IF has already lost STARVE_MAX grants in a row.
   always_comb begin
      grant_mem = bus.mem_req && !(bus.if_req && (starve_cnt == SW'(STARVE_MAX)));
      grant_if  = bus.if_req && !grant_mem;
   end

   // An ack in the expiry cycle still counts as a successful access; writes return zero data.
   always_comb begin
      finish    = bus.ram_ack || expire;
      done_data = (bus.ram_ack && !ram_we_q) ? bus.ram_rdata : '0;
   end

   arb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (!busy),
      .enable (busy),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state       <= ARB_IDLE;
         starve_cnt  <= '0;
         ram_ce_q    <= CHIP_DISABLE;
         ram_we_q    <= WRITE_DISABLE;
         ram_addr_q  <= '0;
         ram_sel_q   <= '0;
         ram_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         if_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         mem_ack_q   <= 1'b0;
         mem_err_q   <= 1'b0;
         mem_rdata_q <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (grant_mem) begin
                  state       <= ARB_BUSY_MEM;
                  ram_ce_q    <= CHIP_ENABLE;
                  ram_we_q    <= bus.mem_we;
                  ram_addr_q  <= bus.mem_addr;
                  ram_sel_q   <= bus.mem_sel;
                  ram_wdata_q <= bus.mem_wdata;
                  if (bus.if_req && (starve_cnt != SW'(STARVE_MAX))) begin
                     starve_cnt <= starve_cnt + SW'(1);
                  end
               end else if (grant_if) begin
                  state       <= ARB_BUSY_IF;
                  ram_ce_q    <= CHIP_ENABLE;
                  ram_we_q    <= WRITE_DISABLE;
                  ram_addr_q  <= bus.if_addr;
                  ram_sel_q   <= SEL_ALL;
                  ram_wdata_q <= '0;
                  starve_cnt  <= '0;
               end
            end
            ARB_BUSY_IF: begin
               if (finish) begin
                  state      <= ARB_DONE;
                  ram_ce_q   <= CHIP_DISABLE;
                  ram_we_q   <= WRITE_DISABLE;
                  if_ack_q   <= 1'b1;
                  if_err_q   <= !bus.ram_ack;
                  if_rdata_q <= done_data;
               end
            end
            ARB_BUSY_MEM: begin
               if (finish) begin
                  state       <= ARB_DONE;
                  ram_ce_q    <= CHIP_DISABLE;
                  ram_we_q    <= WRITE_DISABLE;
                  mem_ack_q   <= 1'b1;
                  mem_err_q   <= !bus.ram_ack;
                  mem_rdata_q <= done_data;
               end
            end
            default: begin
               state     <= ARB_IDLE;
               if_ack_q  <= 1'b0;
               if_err_q  <= 1'b0;
               mem_ack_q <= 1'b0;
               mem_err_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ram_ce       = ram_ce_q;
   assign bus.ram_we       = ram_we_q;
   assign bus.ram_addr     = ram_addr_q;
   assign bus.ram_sel      = ram_sel_q;
   assign bus.ram_wdata    = ram_wdata_q;
   assign bus.if_ack       = if_ack_q;
   assign bus.if_err       = if_err_q;
   assign bus.if_rdata     = if_rdata_q;
   assign bus.mem_ack      = mem_ack_q;
   assign bus.mem_err      = mem_err_q;
   assign bus.mem_rdata    = mem_rdata_q;
   assign bus.stallreq_if  = bus.if_req & ~if_ack_q;
   assign bus.stallreq_mem = bus.mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grants and responses are queued at issue time
// and checked by a memory responder and an ack monitor running independently of the stimulus.
module tb_mem_port_arbiter;
   localparam int TIMEOUT    = 15;
   localparam int STARVE_MAX = 4;

   typedef struct {
      bit          is_mem;
      logic [31:0] rdata;
      bit          err;
      int          exp_cycle;
   } resp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } grant_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          ack_delay = 0;
   bit          manual_ack = 1'b0;
   logic [31:0] resp_data = 32'h0;
   resp_t       resp_q[$];
   grant_t      grant_q[$];

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .TIMEOUT    (TIMEOUT),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory model: checks each grant against the queue and holds ram_* against it while ce is high.
   initial begin : responder
      int     busy_cnt;
      grant_t cur;
      busy_cnt      = 0;
      cur           = '{we: 1'b0, addr: 32'h0, sel: 4'h0, wdata: 32'h0};
      bus.ram_ack   = 1'b0;
      bus.ram_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (bus.ram_ce) busy_cnt++;
         else            busy_cnt = 0;
         if (bus.ram_ce && busy_cnt == 1) begin
            if (grant_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_grant actual=ram_ce required=idle (cycle %0d)", cyc);
            end else begin
               cur = grant_q.pop_front();
               check_output("grant_we",    bus.ram_we,    cur.we);
               check_output("grant_addr",  bus.ram_addr,  cur.addr);
               check_output("grant_sel",   bus.ram_sel,   cur.sel);
               check_output("grant_wdata", bus.ram_wdata, cur.wdata);
            end
         end else if (bus.ram_ce) begin
            check_output("ram_hold", {bus.ram_we, bus.ram_addr, bus.ram_sel, bus.ram_wdata},
                         {cur.we, cur.addr, cur.sel, cur.wdata});
         end
         bus.ram_ack   = (bus.ram_ce && ack_delay != 0 && busy_cnt == ack_delay) || manual_ack;
         bus.ram_rdata = resp_data;
      end
   end

   // Ack monitor: pops one expected response per ack pulse.
   initial begin : monitor
      resp_t r;
      forever begin
         @(negedge clk);
         if (bus.if_ack || bus.mem_ack) begin
            if (resp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL unexpected_ack actual=%b%b required=00 (cycle %0d)",
                        bus.mem_ack, bus.if_ack, cyc);
            end else begin
               r = resp_q.pop_front();
               check_output("ack_port", {bus.mem_ack, bus.if_ack}, r.is_mem ? 2'b10 : 2'b01);
               check_output("rdata", r.is_mem ? bus.mem_rdata : bus.if_rdata, r.rdata);
               check_output("err",   r.is_mem ? bus.mem_err   : bus.if_err,   r.err);
               if (r.exp_cycle >= 0) check_output("latency", cyc, r.exp_cycle);
            end
         end
      end
   end

   // One access from one requester; delay 0 means the memory never answers.
   task automatic apply_stimulus(input bit is_mem, input bit we, input logic [31:0] addr,
                                 input logic [3:0] sel, input logic [31:0] wdata,
                                 input int delay, input logic [31:0] data);
      grant_t g;
      resp_t  r;
      bit     seen;
      ack_delay = delay;
      resp_data = data;
      g = is_mem ? '{we: we, addr: addr, sel: sel, wdata: wdata}
                 : '{we: 1'b0, addr: addr, sel: 4'hF, wdata: 32'h0};
      grant_q.push_back(g);
      r.is_mem    = is_mem;
      r.err       = (delay == 0);
      r.rdata     = (delay == 0 || (is_mem && we)) ? 32'h0 : data;
      r.exp_cycle = cyc + 1 + ((delay == 0) ? TIMEOUT : delay);
      resp_q.push_back(r);
      if (is_mem) begin
         bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_addr = addr;
         bus.mem_sel = sel;  bus.mem_wdata = wdata;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = addr;
      end
      seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         if (i == 0) check_output("stallreq", is_mem ? bus.stallreq_mem : bus.stallreq_if, 1'b1);
         if (is_mem ? bus.mem_ack : bus.if_ack) seen = 1'b1;
      end
      bus.if_req  = 1'b0;
      bus.mem_req = 1'b0;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL ack_wait actual=none required=ack within 64 cycles");
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin : stimulus
      int t0;
      int acks;
      bus.if_req = 1'b0; bus.if_addr = 32'h0;
      bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = 32'h0;
      bus.mem_sel = 4'h0; bus.mem_wdata = 32'h0;

      repeat (3) @(negedge clk);
      check_output("rst_ram_ce",    bus.ram_ce,    1'b0);
      check_output("rst_ram_we",    bus.ram_we,    1'b0);
      check_output("rst_ram_addr",  bus.ram_addr,  32'h0);
      check_output("rst_ram_sel",   bus.ram_sel,   4'h0);
      check_output("rst_acks",      {bus.if_ack, bus.mem_ack, bus.if_err, bus.mem_err}, 4'h0);
      check_output("rst_rdata",     {bus.if_rdata, bus.mem_rdata}, 64'h0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] IF read 0x100");
      apply_stimulus(1'b0, 1'b0, 32'h100, 4'hF, 32'h0, 2, 32'hDEADBEEF);
      $display("[TB] MEM write 0x204");
      apply_stimulus(1'b1, 1'b1, 32'h204, 4'b0011, 32'h1234, 3, 32'hFFFF_FFFF);
      $display("[TB] MEM read 0x300");
      apply_stimulus(1'b1, 1'b0, 32'h300, 4'hF, 32'h0, 1, 32'hA5A5_5A5A);
      $display("[TB] MEM timeout");
      apply_stimulus(1'b1, 1'b0, 32'h400, 4'hF, 32'h0, 0, 32'h1111_2222);
      $display("[TB] IF ack on timeout cycle");
      apply_stimulus(1'b0, 1'b0, 32'h104, 4'hF, 32'h0, TIMEOUT, 32'hCAFE_F00D);

      $display("[TB] both requesters held high");
      ack_delay = 1;
      resp_data = 32'h0BAD_F00D;
      t0 = cyc;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) grant_q.push_back('{we: 1'b0, addr: 32'h40, sel: 4'hF, wdata: 32'h0});
         else        grant_q.push_back('{we: 1'b0, addr: 32'h80, sel: 4'hF, wdata: 32'h0});
         resp_q.push_back('{is_mem: (k != 4), rdata: 32'h0BAD_F00D, err: 1'b0,
                            exp_cycle: t0 + 2 + 3 * k});
      end
      bus.if_req = 1'b1; bus.if_addr = 32'h40;
      bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h80; bus.mem_sel = 4'hF;
      acks = 0;
      for (int i = 0; i < 100 && acks < 6; i++) begin
         @(negedge clk);
         if (bus.if_ack || bus.mem_ack) acks++;
      end
      bus.if_req = 1'b0; bus.mem_req = 1'b0;
      check_output("starve_acks", acks, 6);
      repeat (3) @(negedge clk);

      $display("[TB] reset during MEM access");
      ack_delay = 0;
      grant_q.push_back('{we: 1'b0, addr: 32'h500, sel: 4'hF, wdata: 32'h0});
      bus.mem_req = 1'b1; bus.mem_addr = 32'h500;
      repeat (3) @(negedge clk);
      check_output("busy_ram_ce", bus.ram_ce, 1'b1);
      rst = 1'b1; bus.mem_req = 1'b0;
      @(negedge clk);
      check_output("midrst_ram_ce",  bus.ram_ce,  1'b0);
      check_output("midrst_mem_ack", bus.mem_ack, 1'b0);
      rst = 1'b0; manual_ack = 1'b1;
      @(negedge clk);
      manual_ack = 1'b0;
      repeat (4) @(negedge clk);
      check_output("post_rst_ram_ce", bus.ram_ce, 1'b0);

      check_output("resp_q_left",  resp_q.size(),  0);
      check_output("grant_q_left", grant_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
